// File: rtl/rv_pipe_pkg.sv
// Encoding constants shared by the pipeline stages around memory and writeback.
package rv_pipe_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_NONE = 2'b11;

    localparam logic [2:0] R_LB   = 3'b000;
    localparam logic [2:0] R_LH   = 3'b010;
    localparam logic [2:0] R_LW   = 3'b011;
    localparam logic [2:0] R_LBU  = 3'b100;
    localparam logic [2:0] R_LHU  = 3'b101;
    localparam logic [2:0] R_NONE = 3'b111;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

endpackage

// File: rtl/dmem_unit_if.sv
// Request/response bundle between the W-stage select logic and the data-memory stage.
interface dmem_unit_if;
    logic        valid_in;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_sel;
    logic [1:0]  w_sel;
    logic [2:0]  r_sel;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_in;
    logic [31:0] rdata;
    logic [4:0]  rd_out;
    logic [1:0]  wb_sel_out;
    logic        valid_out;
    logic        misalign;

    modport master (
        output valid_in, stall, addr, wdata, dmem_sel, w_sel, r_sel, wb_sel, rd_in,
        input  rdata, rd_out, wb_sel_out, valid_out, misalign
    );

    modport slave (
        input  valid_in, stall, addr, wdata, dmem_sel, w_sel, r_sel, wb_sel, rd_in,
        output rdata, rd_out, wb_sel_out, valid_out, misalign
    );
endinterface

// File: rtl/dmem_ram.sv
// Word-organised data RAM: byte-enable synchronous write, synchronous registered read.
module dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: executes loads/stores against dmem_ram, blocks misaligned
// accesses, and returns extended load data alongside the registered writeback fields.
module dmem_unit
    import rv_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_unit_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_store;
    logic          is_load;
    logic          mis;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [3:0]    we;
    logic          re;
    logic [31:0]   ram_q;
    logic          unused_addr_hi;

    logic [2:0]    kind_q;
    logic [1:0]    lane_q;
    logic [4:0]    rd_q;
    logic [1:0]    wb_q;
    logic          valid_q;
    logic          mis_q;

    assign idx  = bus.addr[AW+1:2];
    assign lane = bus.addr[1:0];
    assign unused_addr_hi = ^bus.addr[31:AW+2];

    // Request decode, alignment check and lane enables.
    always_comb begin
        is_store = 1'b0;
        is_load  = 1'b0;
        mis      = 1'b0;
        be       = 4'b0000;
        wrep     = bus.wdata;
        if (bus.valid_in && bus.dmem_sel) begin
            is_store = (bus.w_sel != W_NONE);
            case (bus.w_sel)
                W_BYTE: begin
                    be   = 4'b0001 << lane;
                    wrep = {4{bus.wdata[7:0]}};
                end
                W_HALF: begin
                    mis  = lane[0];
                    be   = lane[1] ? 4'b1100 : 4'b0011;
                    wrep = {2{bus.wdata[15:0]}};
                end
                W_WORD: begin
                    mis = |lane;
                    be  = 4'b1111;
                end
                default: ;
            endcase
        end else if (bus.valid_in) begin
            case (bus.r_sel)
                R_LB, R_LBU: is_load = 1'b1;
                R_LH, R_LHU: begin
                    is_load = 1'b1;
                    mis     = lane[0];
                end
                R_LW: begin
                    is_load = 1'b1;
                    mis     = |lane;
                end
                default: ;
            endcase
        end
        // A store presented while reset is asserted must not reach the RAM.
        we = (is_store && !mis && !bus.stall && rst_n) ? be : 4'b0000;
        re = is_load && !mis && !bus.stall;
    end

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .idx   (idx),
        .wdata (wrep),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q  <= R_NONE;
            lane_q  <= 2'b00;
            rd_q    <= 5'd0;
            wb_q    <= WB_NONE;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else if (!bus.stall) begin
            kind_q  <= (is_load && !mis) ? bus.r_sel : R_NONE;
            lane_q  <= lane;
            rd_q    <= bus.rd_in;
            wb_q    <= bus.wb_sel;
            valid_q <= bus.valid_in && !mis;
            mis_q   <= mis;
        end
    end

    // Lane select and extension from the registered RAM word; non-loads read as zero.
    always_comb begin
        bus.rdata = 32'd0;
        case (kind_q)
            R_LB:  bus.rdata = {{24{ram_q[{lane_q, 3'b000} + 5'd7]}}, ram_q[{lane_q, 3'b000} +: 8]};
            R_LBU: bus.rdata = {24'd0, ram_q[{lane_q, 3'b000} +: 8]};
            R_LH:  bus.rdata = lane_q[1] ? {{16{ram_q[31]}}, ram_q[31:16]}
                                         : {{16{ram_q[15]}}, ram_q[15:0]};
            R_LHU: bus.rdata = lane_q[1] ? {16'd0, ram_q[31:16]} : {16'd0, ram_q[15:0]};
            R_LW:  bus.rdata = ram_q;
            default: ;
        endcase
    end

    assign bus.rd_out     = rd_q;
    assign bus.wb_sel_out = wb_q;
    assign bus.valid_out  = valid_q;
    assign bus.misalign   = mis_q;
endmodule

// File: tb/tb_dmem_unit.sv
// Randomized and directed bench for dmem_unit against a byte-array memory model.
module tb_dmem_unit;
    import rv_pipe_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NBYTE = 4 * DEPTH;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0]  bmem [NBYTE];
    logic [31:0] exp_rdata;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_wb;
    logic        exp_valid;
    logic        exp_mis;

    dmem_unit_if bus ();

    dmem_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".rdata"}, bus.rdata, exp_rdata);
        check({tag, ".rd"}, 32'(bus.rd_out), 32'(exp_rd));
        check({tag, ".wb"}, 32'(bus.wb_sel_out), 32'(exp_wb));
        check({tag, ".valid"}, 32'(bus.valid_out), 32'(exp_valid));
        check({tag, ".mis"}, 32'(bus.misalign), 32'(exp_mis));
    endtask

    task automatic set_reset_exp();
        exp_rdata = 32'd0;
        exp_rd    = 5'd0;
        exp_wb    = 2'b11;
        exp_valid = 1'b0;
        exp_mis   = 1'b0;
    endtask

    // One request per clock; the model works on bytes and access sizes.
    task automatic step(input string tag, input logic v, input logic st, input logic ds,
                        input logic [1:0] ws, input logic [2:0] rs, input logic [1:0] wb,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd);
        int  ba;
        int  sz;
        bit  st_op;
        bit  ld_op;
        bit  bad;
        logic [31:0] val;
        bus.valid_in = v;
        bus.stall    = st;
        bus.dmem_sel = ds;
        bus.w_sel    = ws;
        bus.r_sel    = rs;
        bus.wb_sel   = wb;
        bus.rd_in    = rd;
        bus.addr     = a;
        bus.wdata    = wd;
        if (!st) begin
            ba    = int'(a % NBYTE);
            st_op = v && ds && (ws != 2'b11);
            ld_op = v && !ds && (rs == 3'd0 || rs == 3'd2 || rs == 3'd3 || rs == 3'd4 || rs == 3'd5);
            sz    = 0;
            if (st_op) sz = (ws == 2'b00) ? 1 : (ws == 2'b01) ? 2 : 4;
            if (ld_op) sz = (rs == 3'd0 || rs == 3'd4) ? 1 : (rs == 3'd3) ? 4 : 2;
            bad = (st_op || ld_op) && (ba % sz != 0);
            val = 32'd0;
            if (ld_op && !bad) begin
                for (int k = 0; k < sz; k++) val = val | (32'(bmem[ba + k]) << (8 * k));
                if (rs == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
                if (rs == 3'd2 && val[15]) val = val | 32'hFFFF_0000;
            end
            if (st_op && !bad) begin
                for (int k = 0; k < sz; k++) bmem[ba + k] = 8'(wd >> (8 * k));
            end
            exp_rdata = val;
            exp_rd    = rd;
            exp_wb    = wb;
            exp_valid = v && !bad;
            exp_mis   = bad;
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic store(input string tag, input logic [1:0] ws, input logic [31:0] a, input logic [31:0] d);
        step(tag, 1'b1, 1'b0, 1'b1, ws, 3'b000, WB_NONE, 5'd0, a, d);
    endtask

    task automatic load(input string tag, input logic [2:0] rs, input logic [31:0] a);
        step(tag, 1'b1, 1'b0, 1'b0, W_NONE, rs, WB_MEM, 5'd9, a, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < int'(NBYTE); i++) bmem[i] = 8'd0;
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.stall    = 1'b0;
        bus.dmem_sel = 1'b0;
        bus.w_sel    = W_NONE;
        bus.r_sel    = R_NONE;
        bus.wb_sel   = WB_NONE;
        bus.rd_in    = 5'd0;
        bus.addr     = 32'd0;
        bus.wdata    = 32'd0;
        set_reset_exp();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        rst_n = 1'b1;

        // Clear the region used by the rest of the run.
        for (int w = 0; w < 32; w++) store("init", W_WORD, 32'(w * 4), 32'd0);

        store("sw10", W_WORD, 32'h10, 32'hDEAD_BEEF);
        load("lw10", R_LW, 32'h10);
        check("tp_lw10", bus.rdata, 32'hDEAD_BEEF);
        check("tp_lw10_valid", 32'(bus.valid_out), 32'd1);

        store("sb21", W_BYTE, 32'h21, 32'h0000_0080);
        load("lb21", R_LB, 32'h21);
        check("tp_lb21", bus.rdata, 32'hFFFF_FF80);
        load("lbu21", R_LBU, 32'h21);
        check("tp_lbu21", bus.rdata, 32'h0000_0080);
        load("lw20", R_LW, 32'h20);
        check("tp_lw20", bus.rdata, 32'h0000_8000);

        store("sh32", W_HALF, 32'h32, 32'h0000_8001);
        load("lh32", R_LH, 32'h32);
        check("tp_lh32", bus.rdata, 32'hFFFF_8001);
        load("lhu32", R_LHU, 32'h32);
        check("tp_lhu32", bus.rdata, 32'h0000_8001);
        load("lh30", R_LH, 32'h30);
        check("tp_lh30", bus.rdata, 32'h0000_0000);

        load("lw13", R_LW, 32'h13);
        check("tp_lw13_mis", 32'(bus.misalign), 32'd1);
        check("tp_lw13_valid", 32'(bus.valid_out), 32'd0);
        store("sh15", W_HALF, 32'h15, 32'h0000_ABCD);
        check("tp_sh15_mis", 32'(bus.misalign), 32'd1);
        load("lw14", R_LW, 32'h14);
        check("tp_lw14", bus.rdata, 32'h0000_0000);
        check("tp_lw14_mis", 32'(bus.misalign), 32'd0);

        // Stalled store to the address of a completed load.
        store("sw40", W_WORD, 32'h40, 32'hCAFE_F00D);
        load("lw40", R_LW, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b1, 1'b1, W_WORD, R_NONE, WB_ALU, 5'd3, 32'h40, 32'h1111_1111);
            check("tp_stall_hold", bus.rdata, 32'hCAFE_F00D);
        end
        load("lw40b", R_LW, 32'h40);
        check("tp_stall_mem", bus.rdata, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a load; store during reset is dropped.
        bus.valid_in = 1'b1;
        bus.dmem_sel = 1'b0;
        bus.r_sel    = R_LW;
        bus.addr     = 32'h10;
        #2;
        rst_n = 1'b0;
        #1;
        set_reset_exp();
        check_outs("rst_async");
        bus.dmem_sel = 1'b1;
        bus.w_sel    = W_WORD;
        bus.wdata    = 32'h1234_5678;
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        rst_n = 1'b1;
        load("alias", R_LW, 32'(NBYTE) + 32'h10);
        check("tp_alias", bus.rdata, 32'hDEAD_BEEF);

        // Random traffic in words 0..31 with ignored upper address bits.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom), 5'($urandom),
                 a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
